// File: rtl/dpram_write_conflict.sv
// Dual-port RAM with read-first ports, port-A priority on same-address
// write collisions, and a registered collision flag.
module dpram_write_conflict #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_q;
  logic                  conflict_q;
  logic                  conflict_d;
  logic                  we_b_eff_c;

  // Collision detect; port B's write is dropped when it collides with port A.
  always_comb begin
    conflict_d = 1'b0;
    we_b_eff_c = we_b;
    if (we_a && we_b && (addr_a == addr_b)) begin
      conflict_d = 1'b1;
      we_b_eff_c = 1'b0;
    end
  end

  // Storage array; reset clears every word without needing a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_b_eff_c) begin
        mem_q[addr_b] <= din_b;
      end
      if (we_a) begin
        mem_q[addr_a] <= din_a;
      end
    end
  end

  // Read-first output registers and collision flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      dout_a_q   <= mem_q[addr_a];
      dout_b_q   <= mem_q[addr_b];
      conflict_q <= conflict_d;
    end
  end

  assign dout_a   = dout_a_q;
  assign dout_b   = dout_b_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_dpram_write_conflict.sv
// Scoreboard bench for dpram_write_conflict: stimulus pushes expected
// outputs per edge, a monitor pops and compares just after each edge.
module tb_dpram_write_conflict;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c;
    string         name;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a;
  logic [DW-1:0] dout_a;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b;
  logic [DW-1:0] dout_b;
  logic          conflict;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  dpram_write_conflict #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_a     (we_a),
    .addr_a   (addr_a),
    .din_a    (din_a),
    .dout_a   (dout_a),
    .we_b     (we_b),
    .addr_b   (addr_b),
    .din_b    (din_b),
    .dout_b   (dout_b),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [DW-1:0] ea,
                         input logic [DW-1:0] eb, input logic ec);
    checks++;
    if (dout_a !== ea || dout_b !== eb || conflict !== ec) begin
      errors++;
      $display("FAIL %s: got a=%h b=%h c=%b, expected a=%h b=%h c=%b",
               name, dout_a, dout_b, conflict, ea, eb, ec);
    end
  endtask

  // Monitor: every edge with a pending expectation is checked 1ns after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare(e.name, e.a, e.b, e.c);
    end
  end

  // Drive one edge worth of inputs and queue the expected post-edge outputs.
  task automatic cycle(input string name,
                       input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic ec);
    exp_t e;
    @(negedge clk);
    we_a = wa; addr_a = aa; din_a = da;
    we_b = wb; addr_b = ab; din_b = db;
    e.a = ea; e.b = eb; e.c = ec; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    we_a = 1'b0; addr_a = '0; din_a = '0;
    we_b = 1'b0; addr_b = '0; din_b = '0;
    #3;
    compare("reset_immediate", 8'h00, 8'h00, 1'b0);
    // Writes attempted during reset must not land.
    we_a = 1'b1; addr_a = 4'd5; din_a = 8'hFF;
    we_b = 1'b1; addr_b = 4'd5; din_b = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_held", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    rst_n = 1'b1;

    // Every address reads zero on both ports.
    for (int i = 0; i < 16; i++) begin
      cycle("reset_sweep", 1'b0, AW'(i), 8'h00, 1'b0, AW'(15 - i), 8'h00,
            8'h00, 8'h00, 1'b0);
    end

    cycle("a_write3",    1'b1, 4'd3, 8'hA5, 1'b0, 4'd3, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle("read3",       1'b0, 4'd3, 8'h00, 1'b0, 4'd3, 8'h00, 8'hA5, 8'hA5, 1'b0);
    cycle("b_write7",    1'b0, 4'd7, 8'h00, 1'b1, 4'd7, 8'h5A, 8'h00, 8'h00, 1'b0);
    cycle("read7_3",     1'b0, 4'd7, 8'h00, 1'b0, 4'd3, 8'h00, 8'h5A, 8'hA5, 1'b0);
    cycle("read7_7",     1'b0, 4'd7, 8'h00, 1'b0, 4'd7, 8'h00, 8'h5A, 8'h5A, 1'b0);
    cycle("collide5",    1'b1, 4'd5, 8'hF0, 1'b1, 4'd5, 8'h0F, 8'h00, 8'h00, 1'b1);
    cycle("read5",       1'b0, 4'd5, 8'h00, 1'b0, 4'd5, 8'h00, 8'hF0, 8'hF0, 1'b0);
    cycle("dual_write",  1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 8'h00, 8'h00, 1'b0);
    cycle("read1_2",     1'b0, 4'd1, 8'h00, 1'b0, 4'd2, 8'h00, 8'h11, 8'h22, 1'b0);
    cycle("collide4_1",  1'b1, 4'd4, 8'h44, 1'b1, 4'd4, 8'h99, 8'h00, 8'h00, 1'b1);
    cycle("collide4_2",  1'b1, 4'd4, 8'h45, 1'b1, 4'd4, 8'h98, 8'h44, 8'h44, 1'b1);
    cycle("read4",       1'b0, 4'd4, 8'h00, 1'b0, 4'd4, 8'h00, 8'h45, 8'h45, 1'b0);
    cycle("rf_write3",   1'b1, 4'd3, 8'hC3, 1'b0, 4'd3, 8'h00, 8'hA5, 8'hA5, 1'b0);
    cycle("rf_read3",    1'b0, 4'd3, 8'h00, 1'b0, 4'd3, 8'h00, 8'hC3, 8'hC3, 1'b0);
    cycle("rf_b_write6", 1'b0, 4'd6, 8'h00, 1'b1, 4'd6, 8'h66, 8'h00, 8'h00, 1'b0);
    cycle("read6",       1'b0, 4'd6, 8'h00, 1'b0, 4'd6, 8'h00, 8'h66, 8'h66, 1'b0);
    cycle("top_addr",    1'b1, 4'd15, 8'hE7, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle("read15_0",    1'b0, 4'd15, 8'h00, 1'b0, 4'd0, 8'h00, 8'hE7, 8'h00, 1'b0);
    // Leave outputs non-zero (and conflict high) just before reset.
    cycle("collide5_2",  1'b1, 4'd5, 8'h77, 1'b1, 4'd5, 8'h88, 8'hF0, 8'hF0, 1'b1);
    drain();

    // Mid-run reset between edges, with a write pending at the next edge.
    @(negedge clk);
    we_a = 1'b1; addr_a = 4'd5; din_a = 8'h12;
    we_b = 1'b0; addr_b = 4'd5;
    rst_n = 1'b0;
    #1;
    compare("midrun_reset", 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    compare("reset_cancel_edge", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    we_a = 1'b0;
    rst_n = 1'b1;

    cycle("post_reset5", 1'b0, 4'd5, 8'h00, 1'b0, 4'd5, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle("post_reset3", 1'b0, 4'd3, 8'h00, 1'b0, 4'd4, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle("post_write",  1'b1, 4'd9, 8'h3C, 1'b0, 4'd9, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle("post_read9",  1'b0, 4'd9, 8'h00, 1'b0, 4'd9, 8'h00, 8'h3C, 8'h3C, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
